// File: rtl/key_event_scheduler.sv
// key_event_scheduler
//   Turns debounced switch levels into press / long / repeat key events,
//   arbitrates them (lowest key first, press > long > repeat) and queues
//   them in a small FIFO read through a valid/ready port.
//   Optional feature macro: KEY_REPEAT_EN (auto-repeat events while held long).
//
//   Event port handshake: an event transfers on every clk edge where
//   evt_valid and evt_ready are both high. evt_valid never depends on
//   evt_ready, and once evt_valid is high the head {evt_key, evt_type}
//   stays unchanged until that transfer happens.
module key_event_scheduler #(
    parameter int NUM_KEYS     = 5,
    parameter int HOLD_TICKS   = 10,
    parameter int REPEAT_TICKS = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_10hz,
    input  logic [NUM_KEYS-1:0]   sw,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [2:0]            evt_key,
    output logic [1:0]            evt_type,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic [2*NUM_KEYS-1:0] dbg_key_state
);

    localparam int CW = ($clog2(HOLD_TICKS + REPEAT_TICKS) > 4) ?
                        $clog2(HOLD_TICKS + REPEAT_TICKS) : 4;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);
`endif

    localparam logic [1:0] T_PRESS = 2'b00;
    localparam logic [1:0] T_LONG  = 2'b01;
    localparam logic [1:0] T_REP   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } key_state_t;

    logic [NUM_KEYS-1:0] sw_q;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] rel;

    key_state_t    state_q [NUM_KEYS];
    key_state_t    state_d [NUM_KEYS];
    logic [CW-1:0] cnt_q   [NUM_KEYS];
    logic [CW-1:0] cnt_d   [NUM_KEYS];

    logic [NUM_KEYS-1:0] gen_press, gen_long;
    logic [NUM_KEYS-1:0] pend_press, pend_long;
`ifdef KEY_REPEAT_EN
    logic [NUM_KEYS-1:0] gen_rep;
    logic [NUM_KEYS-1:0] pend_rep;
`endif
    logic [NUM_KEYS-1:0] pend_any;
    logic                drop;

    logic                grant;
    logic [NUM_KEYS-1:0] grant_oh;
    logic [2:0]          grant_key;
    logic [1:0]          grant_type;

    logic [AW:0] wr_ptr, rd_ptr;
    logic [4:0]  mem [FIFO_DEPTH];
    logic        full, empty, pop;

    assign press = sw & ~sw_q;
    assign rel   = ~sw & sw_q;

    // Per-key hold FSM: next state, hold counter and generated events.
    always_comb begin
        gen_press = '0;
        gen_long  = '0;
`ifdef KEY_REPEAT_EN
        gen_rep   = '0;
`endif
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (rel[k]) begin
                state_d[k] = ST_IDLE;
                cnt_d[k]   = '0;
            end else if (press[k]) begin
                // A press in a tick cycle restarts the hold; the tick is ignored.
                state_d[k]   = ST_HELD;
                cnt_d[k]     = '0;
                gen_press[k] = 1'b1;
            end else if (tick_10hz) begin
                case (state_q[k])
                    ST_HELD: begin
                        if (cnt_q[k] == HOLD_LAST) begin
                            gen_long[k] = 1'b1;
                            cnt_d[k]    = '0;
                            state_d[k]  = ST_LONG;
                        end else begin
                            cnt_d[k] = cnt_q[k] + 1'b1;
                        end
                    end
`ifdef KEY_REPEAT_EN
                    ST_LONG: begin
                        if (cnt_q[k] == REP_LAST) begin
                            gen_rep[k] = 1'b1;
                            cnt_d[k]   = '0;
                        end else begin
                            cnt_d[k] = cnt_q[k] + 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Per-key FSM state and hold counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    // Expose every key state, two bits per key, key 0 in the low bits.
    always_comb begin
        dbg_key_state = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            dbg_key_state[2*k +: 2] = state_q[k];
        end
    end

    // An event arriving while its pending bit is still set is lost.
    always_comb begin
        pend_any = pend_press | pend_long;
        drop     = (|(gen_press & pend_press)) | (|(gen_long & pend_long));
`ifdef KEY_REPEAT_EN
        pend_any = pend_any | pend_rep;
        drop     = drop | (|(gen_rep & pend_rep));
`endif
    end

    // Arbiter: lowest pending key wins, press before long before repeat.
    // A full FIFO blocks the grant even when a pop happens this cycle.
    always_comb begin
        grant      = 1'b0;
        grant_oh   = '0;
        grant_key  = '0;
        grant_type = T_PRESS;
        if (!full) begin
            for (int k = NUM_KEYS - 1; k >= 0; k--) begin
                if (pend_any[k]) begin
                    grant       = 1'b1;
                    grant_oh    = '0;
                    grant_oh[k] = 1'b1;
                    grant_key   = 3'(k);
                    if (pend_press[k])     grant_type = T_PRESS;
                    else if (pend_long[k]) grant_type = T_LONG;
                    else                   grant_type = T_REP;
                end
            end
        end
    end

    // Edge-detect register, pending bits and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_q       <= '0;
            pend_press <= '0;
            pend_long  <= '0;
`ifdef KEY_REPEAT_EN
            pend_rep   <= '0;
`endif
            ovf        <= 1'b0;
        end else begin
            sw_q       <= sw;
            pend_press <= (pend_press & ~(grant_oh & {NUM_KEYS{grant_type == T_PRESS}}))
                          | (gen_press & ~pend_press);
            pend_long  <= (pend_long & ~(grant_oh & {NUM_KEYS{grant_type == T_LONG}}))
                          | (gen_long & ~pend_long);
`ifdef KEY_REPEAT_EN
            pend_rep   <= (pend_rep & ~(grant_oh & {NUM_KEYS{grant_type == T_REP}}))
                          | (gen_rep & ~pend_rep);
`endif
            if (ovf_clr)   ovf <= 1'b0;
            else if (drop) ovf <= 1'b1;
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign evt_valid = ~empty;
    assign pop       = evt_valid & evt_ready;
    assign {evt_key, evt_type} = empty ? 5'd0 : mem[rd_ptr[AW-1:0]];

    // FIFO pointers; the wrap bit separates full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (grant) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; entries are only read while valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (grant) mem[wr_ptr[AW-1:0]] <= {grant_key, grant_type};
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: vector table, directed multi-cycle sequences and
// randomized traffic for key_event_scheduler, checked against a queue model.
module tb_key_event_scheduler;

    localparam int NK    = 5;
    localparam int HOLD  = 10;
    localparam int REP   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick_10hz = 1'b0;
    logic [NK-1:0] sw = '0;
    logic          evt_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          evt_valid;
    logic [2:0]    evt_key;
    logic [1:0]    evt_type;
    logic          ovf;
    logic [2*NK-1:0] dbg_key_state;

    int checks   = 0;
    int failures = 0;

    key_event_scheduler #(
        .NUM_KEYS(NK), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .tick_10hz(tick_10hz), .sw(sw),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
        .evt_type(evt_type), .ovf(ovf), .ovf_clr(ovf_clr),
        .dbg_key_state(dbg_key_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    // A key is held while its previous level is 1; m_cnt counts ticks since
    // the press, long fires at HOLD ticks, repeats every REP ticks after that.
    bit         m_prev [NK];
    int         m_cnt  [NK];
    bit         m_pend [NK][3];
    bit         m_ovf;
    logic [4:0] exp_q[$];

    function automatic void model_reset();
        for (int k = 0; k < NK; k++) begin
            m_prev[k] = 1'b0;
            m_cnt[k]  = 0;
            for (int t = 0; t < 3; t++) m_pend[k][t] = 1'b0;
        end
        m_ovf = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_step();
        bit ev [NK][3];
        bit newset [NK][3];
        bit drop;
        int gk;
        int gt;
        drop = 1'b0;
        gk = -1;
        gt = 0;
        for (int k = 0; k < NK; k++) begin
            for (int t = 0; t < 3; t++) begin
                ev[k][t] = 1'b0;
                newset[k][t] = 1'b0;
            end
            if (sw[k] && !m_prev[k]) begin
                ev[k][0] = 1'b1;
                m_cnt[k] = 0;
            end else if (sw[k] && m_prev[k] && tick_10hz) begin
                m_cnt[k]++;
                if (m_cnt[k] == HOLD) ev[k][1] = 1'b1;
`ifdef KEY_REPEAT_EN
                if (m_cnt[k] > HOLD && ((m_cnt[k] - HOLD) % REP) == 0) ev[k][2] = 1'b1;
`endif
            end
        end
        if (exp_q.size() < DEPTH) begin
            for (int k = 0; k < NK; k++) begin
                for (int t = 0; t < 3; t++) begin
                    if (gk < 0 && m_pend[k][t]) begin
                        gk = k;
                        gt = t;
                    end
                end
            end
        end
        for (int k = 0; k < NK; k++) begin
            for (int t = 0; t < 3; t++) begin
                if (ev[k][t] && m_pend[k][t]) drop = 1'b1;
                if (ev[k][t] && !m_pend[k][t]) newset[k][t] = 1'b1;
            end
        end
        if (exp_q.size() > 0 && evt_ready) void'(exp_q.pop_front());
        if (gk >= 0) begin
            exp_q.push_back({3'(gk), 2'(gt)});
            m_pend[gk][gt] = 1'b0;
        end
        for (int k = 0; k < NK; k++)
            for (int t = 0; t < 3; t++)
                if (newset[k][t]) m_pend[k][t] = 1'b1;
        if (ovf_clr)   m_ovf = 1'b0;
        else if (drop) m_ovf = 1'b1;
        for (int k = 0; k < NK; k++) m_prev[k] = sw[k];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [4:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 5'd0;
        check("model_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
        check("model_key",   32'(evt_key),   32'(head[4:2]));
        check("model_type",  32'(evt_type),  32'(head[1:0]));
        check("model_ovf",   32'(ovf),       32'(m_ovf));
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_step();
        else     model_reset();
        @(negedge clk);
        compare_model();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NK-1:0] sw;
        logic          ready;
        logic          exp_valid;
        logic [2:0]    exp_key;
        logic [1:0]    exp_type;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs [10];

    int   ev_type[$];
    int   ev_tick[$];
    int   exp_types[$];
    int   exp_ticks[$];
    int   nt;
    int   got_keys[$];
    int   exp_keys[$];
    int   ready_pct;

    task automatic record_event();
        if (evt_valid && evt_ready) begin
            ev_type.push_back(int'(evt_type));
            ev_tick.push_back(nt);
        end
    endtask

    task automatic key_tap(input int k);
        sw[k] = 1'b1;
        cycle();
        cycle();
        sw[k] = 1'b0;
        cycle();
    endtask

    initial begin
        // single key press, then two keys rising in the same clock
        vecs[0] = '{5'b00100, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[1] = '{5'b00100, 1'b1, 1'b1, 3'd2, 2'd0, 1'b0};
        vecs[2] = '{5'b00100, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[3] = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[4] = '{5'b10010, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[5] = '{5'b10010, 1'b0, 1'b1, 3'd1, 2'd0, 1'b0};
        vecs[6] = '{5'b10010, 1'b0, 1'b1, 3'd1, 2'd0, 1'b0};
        vecs[7] = '{5'b10010, 1'b1, 1'b1, 3'd4, 2'd0, 1'b0};
        vecs[8] = '{5'b10010, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[9] = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};

        // reset state
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(evt_valid), 32'd0);
        check("reset_key",   32'(evt_key),   32'd0);
        check("reset_type",  32'(evt_type),  32'd0);
        check("reset_ovf",   32'(ovf),       32'd0);
        check("reset_dbg",   32'(dbg_key_state), 32'd0);
        rst = 1'b1;
        evt_ready = 1'b1;
        cycle();

        // table-driven vectors
        for (int i = 0; i < 10; i++) begin
            sw = vecs[i].sw;
            evt_ready = vecs[i].ready;
            cycle();
            check($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_key", i),   32'(evt_key),   32'(vecs[i].exp_key));
            check($sformatf("vec%0d_type", i),  32'(evt_type),  32'(vecs[i].exp_type));
            check($sformatf("vec%0d_ovf", i),   32'(ovf),       32'(vecs[i].exp_ovf));
        end

        // long hold of key 0 with one tick every 4 clocks
        exp_types.push_back(0); exp_ticks.push_back(0);
        exp_types.push_back(1); exp_ticks.push_back(HOLD);
`ifdef KEY_REPEAT_EN
        exp_types.push_back(2); exp_ticks.push_back(HOLD + REP);
        exp_types.push_back(2); exp_ticks.push_back(HOLD + 2 * REP);
`endif
        evt_ready = 1'b1;
        nt = 0;
        sw = 5'b00001;
        for (int t = 1; t <= 15; t++) begin
            repeat (3) begin
                cycle();
                record_event();
            end
            tick_10hz = 1'b1;
            nt++;
            cycle();
            record_event();
            tick_10hz = 1'b0;
        end
        repeat (3) begin
            cycle();
            record_event();
        end
        sw = '0;
        cycle();
        check("hold_event_count", 32'(ev_type.size()), 32'(exp_types.size()));
        for (int i = 0; i < exp_types.size() && i < ev_type.size(); i++) begin
            check($sformatf("hold_type%0d", i), 32'(ev_type[i]), 32'(exp_types[i]));
            check($sformatf("hold_tick%0d", i), 32'(ev_tick[i]), 32'(exp_ticks[i]));
        end

        // stalled consumer: keys 0..4 pressed 2 clocks apart, FIFO takes four
        evt_ready = 1'b0;
        for (int k = 0; k < NK; k++) begin
            sw[k] = 1'b1;
            cycle();
            cycle();
        end
        cycle();
        check("full_valid", 32'(evt_valid), 32'd1);
        check("full_head",  32'(evt_key),   32'd0);
        evt_ready = 1'b1;
        cycle();
        evt_ready = 1'b0;
        check("pop1_head", 32'(evt_key), 32'd1);
        cycle();
        check("after_pop_ovf", 32'(ovf), 32'd0);
        evt_ready = 1'b1;
        for (int k = 1; k < NK; k++) begin
            check($sformatf("drain_key%0d", k), 32'(evt_key), 32'(k));
            check($sformatf("drain_valid%0d", k), 32'(evt_valid), 32'd1);
            cycle();
        end
        check("drain_empty", 32'(evt_valid), 32'd0);
        sw = '0;
        cycle();

        // drop on re-press while pending, then ovf_clr
        evt_ready = 1'b0;
        key_tap(0);
        key_tap(1);
        key_tap(2);
        key_tap(0);
        sw[3] = 1'b1;
        cycle();
        cycle();
        check("pend3_ovf", 32'(ovf), 32'd0);
        sw[3] = 1'b0;
        cycle();
        sw[3] = 1'b1;
        cycle();
        check("drop_ovf", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check("clr_ovf", 32'(ovf), 32'd0);
        exp_keys = '{0, 1, 2, 0, 3};
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (evt_valid) got_keys.push_back(int'(evt_key));
            cycle();
        end
        check("drop_drain_count", 32'(got_keys.size()), 32'(exp_keys.size()));
        for (int i = 0; i < exp_keys.size() && i < got_keys.size(); i++)
            check($sformatf("drop_drain%0d", i), 32'(got_keys[i]), 32'(exp_keys[i]));
        sw = '0;
        cycle();

        // reset during a hold with the FIFO non-empty
        evt_ready = 1'b0;
        sw = 5'b00001;
        cycle();
        cycle();
        check("pre_rst_valid", 32'(evt_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(evt_valid), 32'd0);
        model_reset();
        cycle();
        rst = 1'b1;
        cycle();
        check("post_rst_wait", 32'(evt_valid), 32'd0);
        cycle();
        check("post_rst_valid", 32'(evt_valid), 32'd1);
        check("post_rst_key",   32'(evt_key),   32'd0);
        check("post_rst_type",  32'(evt_type),  32'd0);
        sw = '0;
        evt_ready = 1'b1;
        cycle();

        // randomized traffic against the model
        ready_pct = 50;
        for (int c = 0; c < 2400; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ready_pct = 10;
                    1:       ready_pct = 50;
                    default: ready_pct = 95;
                endcase
            end
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 39) == 0) sw[k] = ~sw[k];
            tick_10hz = ($urandom_range(0, 2) == 0);
            evt_ready = ($urandom_range(0, 99) < ready_pct);
            ovf_clr   = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
